// File: rtl/bitrev_bank_ctrl_if.sv
// rtl/bitrev_bank_ctrl_if.sv - sample streams and SRAM port bundle for bitrev_bank_ctrl
interface bitrev_bank_ctrl_if #(
    parameter int K  = 10,
    parameter int DW = 32
);
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;

    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;

    logic          sram_we_o;
    logic [K:0]    sram_waddr_o;
    logic [DW-1:0] sram_wdata_o;
    logic          sram_re_o;
    logic [K:0]    sram_raddr_o;
    logic [DW-1:0] sram_rdata_i;

    // slave: the bank controller; master: the surrounding stages and the SRAM
    modport slave (
        input  in_valid_i, in_data_i, out_ready_i, sram_rdata_i,
        output in_ready_o, out_valid_o, out_data_o,
        output sram_we_o, sram_waddr_o, sram_wdata_o,
        output sram_re_o, sram_raddr_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i, sram_rdata_i,
        input  in_ready_o, out_valid_o, out_data_o,
        input  sram_we_o, sram_waddr_o, sram_wdata_o,
        input  sram_re_o, sram_raddr_o
    );
endinterface

// File: rtl/bitrev_bank_ctrl.sv
// rtl/bitrev_bank_ctrl.sv - ping-pong bit-reversal reorder bank controller (perf counters: BITREV_BANK_CTRL_PERF_EN)
module bitrev_bank_ctrl #(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bitrev_bank_ctrl_if.slave bus,
    output logic [1:0]        bank_full_o,
    output logic [15:0]       frame_cnt_o,
    output logic [15:0]       stall_cnt_o
);
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    bank_state_e   state_q [2];
    logic          wr_bank_q;
    logic          rd_bank_q;
    logic [K-1:0]  wr_cnt_q;
    logic [K-1:0]  rd_cnt_q;
    logic          inflight_q;
    logic [DW-1:0] fifo_mem_q [2];
    logic          fifo_wptr_q;
    logic          fifo_rptr_q;
    logic [1:0]    fifo_occ_q;

    logic          wr_open;
    logic          wr_acc;
    logic          wr_last;
    logic          rd_open;
    logic          rd_issue;
    logic          rd_last;
    logic          pop;
    logic [2:0]    pending;

    function automatic logic [K-1:0] bitrev(input logic [K-1:0] v);
        logic [K-1:0] r;
        for (int i = 0; i < K; i++) r[i] = v[K-1-i];
        return r;
    endfunction

    assign wr_open  = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
    assign wr_acc   = bus.in_valid_i && wr_open;
    assign wr_last  = &wr_cnt_q;
    assign rd_open  = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);
    assign pop      = (fifo_occ_q != 2'd0) && bus.out_ready_i;
    // Words already owed to the FIFO once this cycle's pop leaves; cap at two keeps it from overflowing.
    assign pending  = {1'b0, fifo_occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_issue = rd_open && (pending < 3'd2);
    assign rd_last  = &rd_cnt_q;

    assign bus.in_ready_o   = wr_open;
    assign bus.sram_we_o    = wr_acc;
    assign bus.sram_waddr_o = {wr_bank_q, wr_cnt_q};
    assign bus.sram_wdata_o = bus.in_data_i;
    assign bus.sram_re_o    = rd_issue;
    assign bus.sram_raddr_o = {rd_bank_q, bitrev(rd_cnt_q)};
    assign bus.out_valid_o  = (fifo_occ_q != 2'd0);
    assign bus.out_data_o   = fifo_mem_q[fifo_rptr_q];

    assign bank_full_o[0] = (state_q[0] == FULL) || (state_q[0] == DRAINING);
    assign bank_full_o[1] = (state_q[1] == FULL) || (state_q[1] == DRAINING);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            inflight_q  <= 1'b0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_occ_q  <= 2'd0;
        end else begin
            // Write and read never target the same bank: their state preconditions are disjoint.
            if (wr_acc) begin
                state_q[wr_bank_q] <= wr_last ? FULL : FILLING;
                wr_cnt_q           <= wr_cnt_q + K'(1);
                if (wr_last) wr_bank_q <= ~wr_bank_q;
            end
            if (rd_issue) begin
                state_q[rd_bank_q] <= rd_last ? EMPTY : DRAINING;
                rd_cnt_q           <= rd_cnt_q + K'(1);
                if (rd_last) rd_bank_q <= ~rd_bank_q;
            end
            inflight_q <= rd_issue;
            if (inflight_q) fifo_wptr_q <= ~fifo_wptr_q;
            if (pop)        fifo_rptr_q <= ~fifo_rptr_q;
            fifo_occ_q <= fifo_occ_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (inflight_q) fifo_mem_q[fifo_wptr_q] <= bus.sram_rdata_i;
    end

`ifdef BITREV_BANK_CTRL_PERF_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (rd_issue && rd_last) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (bus.in_valid_i && !wr_open && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign frame_cnt_o = 16'd0;
    assign stall_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_bitrev_bank_ctrl.sv
// tb/tb_bitrev_bank_ctrl.sv - directed self-checking bench for bitrev_bank_ctrl (K=3)
module tb_bitrev_bank_ctrl;
    localparam int K  = 3;
    localparam int DW = 32;
    localparam int N  = 8;
`ifdef BITREV_BANK_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  bank_full;
    logic [15:0] frame_cnt;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int tb_stalls;
    int rx_base;
    bit rnd_done;
    int rev_tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [DW-1:0] mem [0:2*N-1];
    logic [DW-1:0] rx_q [$];

    always #5 clk = ~clk;

    bitrev_bank_ctrl_if #(.K(K), .DW(DW)) bus ();

    bitrev_bank_ctrl #(.K(K), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .bank_full_o (bank_full),
        .frame_cnt_o (frame_cnt),
        .stall_cnt_o (stall_cnt)
    );

    always @(posedge clk) begin
        if (bus.sram_we_o) mem[bus.sram_waddr_o] <= bus.sram_wdata_o;
        if (bus.sram_re_o) bus.sram_rdata_i <= mem[bus.sram_raddr_o];
    end

    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) rx_q.push_back(bus.out_data_o);
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input int base, input int count);
        int  waited;
        bit  taken;
        for (int i = 0; i < count; i++) begin
            waited = 0;
            taken  = 1'b0;
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = DW'(base + i);
            while (!taken) begin
                @(negedge clk);
                if (bus.in_ready_o) taken = 1'b1;
                else begin
                    tb_stalls++;
                    waited++;
                end
                @(posedge clk); #1;
                if (!taken && waited > 400) begin
                    total++; bad++;
                    $display("FAIL send_timeout sample=%0d got=stalled required=accepted", base + i);
                    taken = 1'b1;
                end
            end
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int cyc;
        cyc = 0;
        while ((rx_q.size() - rx_base) < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if ((rx_q.size() - rx_base) < n) begin
            bad++;
            $display("FAIL rx_timeout got=%0d required=%0d", rx_q.size() - rx_base, n);
        end
    endtask

    task automatic check_frames(input string name, input int base, input int frames);
        logic [DW-1:0] exp_v;
        for (int f = 0; f < frames; f++) begin
            for (int j = 0; j < N; j++) begin
                exp_v = DW'(base + f * N + rev_tab[j]);
                total++;
                if ((rx_base + f * N + j) >= rx_q.size()) begin
                    bad++;
                    $display("FAIL %s_missing idx=%0d got=none required=%0d", name, f * N + j, exp_v);
                end else if (rx_q[rx_base + f * N + j] !== exp_v) begin
                    bad++;
                    $display("FAIL %s idx=%0d got=%0d required=%0d", name, f * N + j,
                             rx_q[rx_base + f * N + j], exp_v);
                end
            end
        end
    endtask

    task automatic do_reset();
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rx_base   = rx_q.size();
        tb_stalls = 0;
    endtask

    task automatic test_reset();
        logic [37:0] got;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        @(negedge clk);
        got = {bus.in_ready_o, bus.out_valid_o, bus.sram_we_o, bus.sram_re_o, bank_full, frame_cnt, stall_cnt};
        total++;
        if (got !== {1'b1, 37'd0}) begin
            bad++;
            $display("FAIL reset_state got=%h required=%h", got, {1'b1, 37'd0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rx_base = rx_q.size();
    endtask

    task automatic test_single_frame();
        do_reset();
        bus.out_ready_i = 1'b1;
        send(0, N);
        @(negedge clk);
        total++;
        if ({bus.sram_re_o, bus.out_valid_o, bus.sram_raddr_o} !== {1'b1, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL latency_first_read got=re%b/ov%b/a%h required=re1/ov0/a0",
                     bus.sram_re_o, bus.out_valid_o, bus.sram_raddr_o);
        end
        @(negedge clk);
        total++;
        if (bus.out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL latency_valid_early got=%b required=0", bus.out_valid_o);
        end
        @(negedge clk);
        total++;
        if (bus.out_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL latency_valid_rise got=%b required=1", bus.out_valid_o);
        end
        wait_rx(N, 100);
        check_frames("single_frame", 0, 1);
    endtask

    task automatic test_stream();
        do_reset();
        bus.out_ready_i = 1'b1;
        send(0, 4 * N);
        total++;
        if (tb_stalls != 0) begin
            bad++;
            $display("FAIL stream_in_ready_drop got=%0d required=0", tb_stalls);
        end
        wait_rx(4 * N, 200);
        check_frames("stream", 0, 4);
        repeat (3) @(negedge clk);
        total++;
        if (frame_cnt !== (PERF ? 16'd4 : 16'd0)) begin
            bad++;
            $display("FAIL stream_frame_cnt got=%0d required=%0d", frame_cnt, PERF ? 4 : 0);
        end
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL stream_stall_cnt got=%0d required=0", stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        int re_seen;
        do_reset();
        bus.out_ready_i = 1'b0;
        send(0, 2 * N);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = DW'(99);
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.in_ready_o, bank_full, bus.out_valid_o} !== 4'b0111) begin
            bad++;
            $display("FAIL bp_flags got=ir%b/bf%b/ov%b required=ir0/bf11/ov1",
                     bus.in_ready_o, bank_full, bus.out_valid_o);
        end
        total++;
        if (stall_cnt !== (PERF ? 16'd5 : 16'd0)) begin
            bad++;
            $display("FAIL bp_stall_cnt got=%0d required=%0d", stall_cnt, PERF ? 5 : 0);
        end
        re_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.sram_re_o) re_seen++;
        end
        total++;
        if (re_seen != 0) begin
            bad++;
            $display("FAIL bp_re_held got=%0d required=0", re_seen);
        end
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        wait_rx(2 * N, 200);
        check_frames("backpressure", 0, 2);
        repeat (6) @(negedge clk);
        total++;
        if ((rx_q.size() - rx_base) != 2 * N) begin
            bad++;
            $display("FAIL bp_extra_words got=%0d required=%0d", rx_q.size() - rx_base, 2 * N);
        end
    endtask

    task automatic test_random_ready();
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                send(1000, 10 * N);
                wait_rx(10 * N, 3000);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    bus.out_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        check_frames("random_ready", 1000, 10);
        total++;
        if ((rx_q.size() - rx_base) != 10 * N) begin
            bad++;
            $display("FAIL random_count got=%0d required=%0d", rx_q.size() - rx_base, 10 * N);
        end
    endtask

    task automatic test_mid_reset();
        logic [37:0] got;
        do_reset();
        bus.out_ready_i = 1'b1;
        send(0, N + 5);
        wait_rx(3, 50);
        rst = 1'b1;
        #1;
        got = {bus.in_ready_o, bus.out_valid_o, bus.sram_we_o, bus.sram_re_o, bank_full, frame_cnt, stall_cnt};
        total++;
        if (got !== {1'b1, 37'd0}) begin
            bad++;
            $display("FAIL mid_reset_state got=%h required=%h", got, {1'b1, 37'd0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rx_base = rx_q.size();
        send(200, N);
        @(negedge clk);
        total++;
        if ({bus.sram_re_o, bus.sram_raddr_o} !== 5'b10000) begin
            bad++;
            $display("FAIL mid_reset_bank0 got=re%b/a%h required=re1/a0", bus.sram_re_o, bus.sram_raddr_o);
        end
        wait_rx(N, 100);
        check_frames("mid_reset", 200, 1);
        repeat (3) @(negedge clk);
        total++;
        if (frame_cnt !== (PERF ? 16'd1 : 16'd0)) begin
            bad++;
            $display("FAIL mid_reset_frame_cnt got=%0d required=%0d", frame_cnt, PERF ? 1 : 0);
        end
    endtask

    initial begin
        rst             = 1'b1;
        rx_base         = 0;
        tb_stalls       = 0;
        rnd_done        = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        test_reset();
        test_single_frame();
        test_stream();
        test_backpressure();
        test_random_ready();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
